// File: rtl/aes256_block_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes256_block_serializer: 2-slot ping-pong buffer for 128-bit ciphertext  |
// | blocks, streamed out MSB-byte first on a byte-wide AXI-Stream master.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module aes256_block_serializer #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [127:0]     blk_data_i,
   input  logic             blk_valid_i,
   input  logic             blk_last_i,
   output logic             blk_ready_o,
   output logic [7:0]       axis_tdata_o,
   output logic             axis_tvalid_o,
   output logic             axis_tlast_o,
   input  logic             axis_tready_i,
   output logic             busy_o,
   output logic [CNT_W-1:0] blocks_sent_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

   occ_e              state_q, state_d;
   logic [1:0][127:0] slot_data_q, slot_data_d;
   logic [1:0]        slot_last_q, slot_last_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [3:0]        byte_idx_q, byte_idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              w_push, w_beat, w_pop;
   logic [127:0]      w_rd_blk;
   logic [6:0]        w_bit_lo;

   // Ready and valid decode from registered occupancy only, so there is no
   // path from axis_tready_i to blk_ready_o.
   assign blk_ready_o   = (state_q != FULL);
   assign axis_tvalid_o = (state_q != EMPTY);
   assign busy_o        = axis_tvalid_o;
   assign blocks_sent_o = cnt_q;

   assign w_push = blk_valid_i & blk_ready_o;
   assign w_beat = axis_tvalid_o & axis_tready_i;
   assign w_pop  = w_beat & (&byte_idx_q);

   // Byte k sits at bits [127-8k -: 8]; low bit index is 8*(15-k) = {~k,3'b0}.
   assign w_rd_blk     = slot_data_q[rd_ptr_q];
   assign w_bit_lo     = {~byte_idx_q, 3'b000};
   assign axis_tdata_o = axis_tvalid_o ? w_rd_blk[w_bit_lo +: 8] : 8'h00;
   assign axis_tlast_o = axis_tvalid_o & (&byte_idx_q) & slot_last_q[rd_ptr_q];

   always_comb begin
      state_d     = state_q;
      slot_data_d = slot_data_q;
      slot_last_d = slot_last_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      byte_idx_d  = byte_idx_q;
      cnt_d       = cnt_q;

      if (w_push) begin
         slot_data_d[wr_ptr_q] = blk_data_i;
         slot_last_d[wr_ptr_q] = blk_last_i;
         wr_ptr_d              = ~wr_ptr_q;
      end

      if (w_beat) begin
         byte_idx_d = byte_idx_q + 4'd1;
      end

      if (w_pop) begin
         rd_ptr_d = ~rd_ptr_q;
         cnt_d    = cnt_q + CNT_W'(1);
      end

      case (state_q)
         EMPTY:   if (w_push)            state_d = ONE;
         ONE:     if (w_push && !w_pop)  state_d = FULL;
                  else if (!w_push && w_pop) state_d = EMPTY;
         FULL:    if (w_pop)             state_d = ONE;
         default:                        state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= EMPTY;
         slot_data_q <= '0;
         slot_last_q <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         byte_idx_q  <= 4'd0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         slot_data_q <= slot_data_d;
         slot_last_q <= slot_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         byte_idx_q  <= byte_idx_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes256_block_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aes256_block_serializer: self-checking bench with a byte-queue model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_aes256_block_serializer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] blk_data = '0;
   logic         blk_valid = 1'b0;
   logic         blk_last = 1'b0;
   logic         tready = 1'b0;

   logic         blk_ready, tvalid, tlast, busy;
   logic [7:0]   tdata;
   logic [15:0]  cnt;
   logic         blk_ready_w, tvalid_w, tlast_w, busy_w;
   logic [7:0]   tdata_w;
   logic [3:0]   cnt_w;

   always #5 clk = ~clk;

   aes256_block_serializer #(.CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .blk_data_i(blk_data), .blk_valid_i(blk_valid),
      .blk_last_i(blk_last), .blk_ready_o(blk_ready), .axis_tdata_o(tdata),
      .axis_tvalid_o(tvalid), .axis_tlast_o(tlast), .axis_tready_i(tready),
      .busy_o(busy), .blocks_sent_o(cnt)
   );

   // Narrow-counter instance: exercises the modulo-2**CNT_W wrap in a short run.
   aes256_block_serializer #(.CNT_W(4)) dut_w (
      .clk_i(clk), .rst_i(rst), .blk_data_i(blk_data), .blk_valid_i(blk_valid),
      .blk_last_i(blk_last), .blk_ready_o(blk_ready_w), .axis_tdata_o(tdata_w),
      .axis_tvalid_o(tvalid_w), .axis_tlast_o(tlast_w), .axis_tready_i(tready),
      .busy_o(busy_w), .blocks_sent_o(cnt_w)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       eob;
      logic       lst;
   } byte_t;

   byte_t       mq[$];
   int unsigned m_sent = 0;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      logic         v;
      logic [127:0] d;
      logic         l;
      logic         tr;
      logic         e_rdy;
      logic         e_val;
      logic [7:0]   e_dat;
      logic         e_lst;
      int           e_cnt;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 30)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [127:0] d, input logic l, input logic tr);
      @(negedge clk);
      blk_valid = v;
      blk_data  = d;
      blk_last  = l;
      tready    = tr;
      #1;
   endtask

   function automatic logic m_ready();
      return (mq.size() <= 16);
   endfunction

   task automatic check_model();
      logic       ev;
      logic [7:0] ed;
      logic       el;
      ev = (mq.size() > 0);
      ed = ev ? mq[0].d : 8'h00;
      el = ev && mq[0].eob && mq[0].lst;
      chk("ready", {31'd0, blk_ready}, {31'd0, m_ready()});
      chk("tvalid", {31'd0, tvalid}, {31'd0, ev});
      chk("busy", {31'd0, busy}, {31'd0, ev});
      chk("tdata", {24'd0, tdata}, {24'd0, ed});
      chk("tlast", {31'd0, tlast}, {31'd0, el});
      chk("blocks_sent", {16'd0, cnt}, m_sent & 32'hFFFF);
      chk("w_tdata", {24'd0, tdata_w}, {24'd0, ed});
      chk("w_ready", {31'd0, blk_ready_w}, {31'd0, m_ready()});
      chk("w_blocks_sent", {28'd0, cnt_w}, m_sent & 32'hF);
   endtask

   // Returns whether the offered block was accepted and whether a byte moved.
   task automatic advance_model(output logic acc, output logic beat);
      logic rdy;
      rdy  = m_ready();
      acc  = blk_valid && rdy;
      beat = (mq.size() > 0) && tready;
      if (beat) begin
         if (mq[0].eob) m_sent++;
         void'(mq.pop_front());
      end
      if (acc) begin
         for (int k = 0; k < 16; k++) begin
            byte_t b;
            b.d   = blk_data[127-8*k -: 8];
            b.eob = (k == 15);
            b.lst = blk_last;
            mq.push_back(b);
         end
      end
   endtask

   task automatic do_reset_check(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk({tag, "_tvalid"}, {31'd0, tvalid}, 32'd0);
      chk({tag, "_tdata"}, {24'd0, tdata}, 32'd0);
      chk({tag, "_tlast"}, {31'd0, tlast}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_ready"}, {31'd0, blk_ready}, 32'd1);
      chk({tag, "_cnt"}, {16'd0, cnt}, 32'd0);
      chk({tag, "_cnt_w"}, {28'd0, cnt_w}, 32'd0);
      mq.delete();
      m_sent = 0;
      @(negedge clk);
      blk_valid = 1'b0;
      tready    = 1'b0;
      rst       = 1'b0;
   endtask

   initial begin
      vec_t         tbl[18];
      logic [127:0] blk_a;
      logic [127:0] blks[3];
      logic         lsts[3];
      logic         acc, beat;
      int           b, nbeats, first_beat, last_beat, cyc;

      blk_a = 128'h00112233_44556677_8899AABB_CCDDEEFF;

      // Single-block table: push at entry 0, bytes 00,11,..,FF on entries 1..16.
      tbl[0] = '{1'b1, blk_a, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0};
      for (int i = 1; i <= 16; i++)
         tbl[i] = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 8'(17 * (i - 1)), (i == 16), 0};
      tbl[17] = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1};

      do_reset_check("rst_init");

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].tr);
         chk($sformatf("tbl%0d_ready", i), {31'd0, blk_ready}, {31'd0, tbl[i].e_rdy});
         chk($sformatf("tbl%0d_tvalid", i), {31'd0, tvalid}, {31'd0, tbl[i].e_val});
         chk($sformatf("tbl%0d_tdata", i), {24'd0, tdata}, {24'd0, tbl[i].e_dat});
         chk($sformatf("tbl%0d_tlast", i), {31'd0, tlast}, {31'd0, tbl[i].e_lst});
         chk($sformatf("tbl%0d_cnt", i), {16'd0, cnt}, tbl[i].e_cnt);
         advance_model(acc, beat);
      end

      // Back-to-back: three blocks with valid held, tready always high.
      for (int i = 0; i < 3; i++) begin
         blks[i] = {$urandom, $urandom, $urandom, $urandom};
         lsts[i] = (i != 0);
      end
      b = 0; nbeats = 0; first_beat = -1; last_beat = -1; cyc = 0;
      while (cyc < 80 && !(b == 3 && mq.size() == 0)) begin
         if (b < 3) drive(1'b1, blks[b], lsts[b], 1'b1);
         else       drive(1'b0, '0, 1'b0, 1'b1);
         check_model();
         if (tvalid && tready) begin
            nbeats++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
         end
         advance_model(acc, beat);
         if (acc) b++;
         cyc++;
      end
      chk("b2b_done", {31'd0, (b == 3 && mq.size() == 0)}, 32'd1);
      chk("b2b_beats", nbeats, 48);
      chk("b2b_contiguous", last_beat - first_beat + 1, 48);

      // Backpressure: two pushes, a third block offered but refused for 40 cycles.
      for (int i = 0; i < 3; i++) blks[i] = {$urandom, $urandom, $urandom, $urandom};
      b = 0; cyc = 0;
      while (cyc < 42) begin
         drive(1'b1, blks[b], b[0], 1'b0);
         check_model();
         advance_model(acc, beat);
         if (acc) b++;
         cyc++;
      end
      chk("bp_ready_low", {31'd0, blk_ready}, 32'd0);
      chk("bp_byte0", {24'd0, tdata}, {24'd0, blks[0][127:120]});
      chk("bp_accepted", b, 2);
      cyc = 0;
      while (cyc < 100 && !(b == 3 && mq.size() == 0)) begin
         if (b < 3) drive(1'b1, blks[b], 1'b1, 1'b1);
         else       drive(1'b0, '0, 1'b0, 1'b1);
         check_model();
         advance_model(acc, beat);
         if (acc) b++;
         cyc++;
      end
      chk("bp_drained", {31'd0, (b == 3 && mq.size() == 0)}, 32'd1);

      // Reset mid-block.
      drive(1'b1, blk_a, 1'b1, 1'b1);
      check_model();
      advance_model(acc, beat);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, '0, 1'b0, 1'b1);
         check_model();
         advance_model(acc, beat);
      end
      do_reset_check("rst_mid");
      drive(1'b0, '0, 1'b0, 1'b1);
      check_model();
      advance_model(acc, beat);

      // Random: 1000 blocks, random valid (held until accepted), tready ~50%.
      b = 0; cyc = 0;
      blks[0] = {$urandom, $urandom, $urandom, $urandom};
      lsts[0] = $urandom_range(0, 1);
      begin
         logic v;
         v = 1'b0;
         while (cyc < 60000 && !(b == 1000 && mq.size() == 0)) begin
            if (!v && b < 1000) v = ($urandom_range(0, 3) != 0);
            drive(v, blks[0], lsts[0], $urandom_range(0, 1));
            check_model();
            advance_model(acc, beat);
            if (acc) begin
               b++;
               v = 1'b0;
               blks[0] = {$urandom, $urandom, $urandom, $urandom};
               lsts[0] = $urandom_range(0, 1);
            end
            cyc++;
         end
      end
      chk("rand_done", {31'd0, (b == 1000 && mq.size() == 0)}, 32'd1);
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("rand_blocks_sent", {16'd0, cnt}, 32'd1000);
      chk("rand_blocks_sent_w", {28'd0, cnt_w}, 32'd8);
      chk("rand_idle", {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
